// File: rtl/sipo_frame_collector.sv
// sipo_frame_collector: gathers NUM_WORDS-beat serial bursts into a double-buffered parallel frame
module sipo_frame_collector #(
  parameter int DATA_W    = 9,
  parameter int NUM_WORDS = 16,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] serial_in,
  input  logic              serial_valid,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] data_out [NUM_WORDS],
  output logic              frame_valid,
  output logic              overflow,
  output logic              runt
);
  typedef enum logic [1:0] {S_COLLECT, S_STALL, S_RESYNC} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);
  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_cap [NUM_WORDS];
  logic              w_accept;
  assign w_accept = frame_valid && frame_ready;
  // capture beats, hand frames to the output register, and drop beats while the double buffer is full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_COLLECT;
      r_idx       <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      runt        <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_cap[i]    <= '0;
        data_out[i] <= '0;
      end
    end else begin
      overflow <= 1'b0;
      runt     <= 1'b0;
      if (w_accept) frame_valid <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (serial_valid) begin
            r_cap[r_idx] <= serial_in;
            r_idx        <= r_idx + 1'b1;
            if (r_idx == LAST) begin
              if (!frame_valid || frame_ready) begin
                for (int i = 0; i < NUM_WORDS; i++)
                  data_out[i] <= (IDX_W'(i) == LAST) ? serial_in : r_cap[i];
                frame_valid <= 1'b1;
              end else begin
                r_state <= S_STALL;
              end
            end
          end else if (r_idx != '0) begin
            runt  <= 1'b1;
            r_idx <= '0;
          end
        end
        S_STALL: begin
          overflow <= serial_valid;
          if (w_accept) begin
            data_out    <= r_cap;
            frame_valid <= 1'b1;
            r_state     <= S_RESYNC;
          end
        end
        default: begin
          overflow <= serial_valid;
          if (!serial_valid) r_state <= S_COLLECT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sipo_frame_collector.sv
// tb_sipo_frame_collector: directed and random bursts checked against a queue-based frame model
module tb_sipo_frame_collector;
  logic       clk;
  logic       reset;
  logic [8:0] serial_in;
  logic       serial_valid;
  logic       frame_ready;
  logic [8:0] data_out [16];
  logic       frame_valid;
  logic       overflow;
  logic       runt;
  int n_asserts = 0;
  int n_fails   = 0;
  logic [8:0] m_out   [16];
  logic [8:0] m_hframe[16];
  logic [8:0] m_burst [$];
  bit m_fv, m_ov, m_rn, m_held, m_resync;

  sipo_frame_collector dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_ready(frame_ready), .data_out(data_out), .frame_valid(frame_valid),
    .overflow(overflow), .runt(runt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check();
    chk("frame_valid", {8'd0, frame_valid}, {8'd0, m_fv});
    chk("overflow", {8'd0, overflow}, {8'd0, m_ov});
    chk("runt", {8'd0, runt}, {8'd0, m_rn});
    for (int i = 0; i < 16; i++) chk($sformatf("data_out[%0d]", i), data_out[i], m_out[i]);
  endtask

  task automatic model_reset();
    m_fv = 0; m_ov = 0; m_rn = 0; m_held = 0; m_resync = 0;
    m_burst.delete();
    for (int i = 0; i < 16; i++) m_out[i] = '0;
  endtask

  task automatic model_step(input bit v, input logic [8:0] d, input bit r);
    bit acc, was_fv;
    acc = m_fv && r;
    was_fv = m_fv;
    m_ov = 0;
    m_rn = 0;
    if (m_held || m_resync) begin
      m_ov = v;
      if (m_held) begin
        if (acc) begin
          m_out = m_hframe;
          m_held = 0;
          m_resync = 1;
        end
      end else begin
        if (acc) m_fv = 0;
        if (!v) m_resync = 0;
      end
    end else begin
      if (acc) m_fv = 0;
      if (v) begin
        m_burst.push_back(d);
        if (m_burst.size() == 16) begin
          if (!was_fv || r) begin
            for (int i = 0; i < 16; i++) m_out[i] = m_burst[i];
            m_fv = 1;
          end else begin
            for (int i = 0; i < 16; i++) m_hframe[i] = m_burst[i];
            m_held = 1;
          end
          m_burst.delete();
        end
      end else if (m_burst.size() != 0) begin
        m_rn = 1;
        m_burst.delete();
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [8:0] d, input bit r);
    serial_valid = v;
    serial_in = d;
    frame_ready = r;
    model_step(v, d, r);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic beats(input int k, input bit r);
    for (int i = 0; i < k; i++) cyc(1'b1, 9'($urandom), r);
  endtask

  initial begin
    reset = 1'b1;
    serial_in = '0;
    serial_valid = 1'b0;
    frame_ready = 1'b0;
    model_reset();
    #3;
    check();
    @(posedge clk);
    #1;
    reset = 1'b0;
    // single clean frame with incrementing samples
    for (int i = 0; i < 16; i++) cyc(1'b1, 9'(i + 1), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    // two bursts with consumer stalled, then 4 dropped beats, then drain
    beats(36, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    // runt burst followed by alternating full-scale frame
    beats(5, 1'b1);
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, (i % 2 == 0) ? 9'h1FF : 9'h000, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    // pending frame plus half a burst, then asynchronous reset between edges
    beats(16, 1'b0);
    beats(8, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("async frame_valid", {8'd0, frame_valid}, 9'd0);
    chk("async data_out[0]", data_out[0], 9'd0);
    chk("async data_out[15]", data_out[15], 9'd0);
    model_reset();
    check();
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 9'(9'h0A0 + i), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    // accept exactly on the last beat of the next frame
    beats(16, 1'b0);
    beats(15, 1'b0);
    cyc(1'b1, 9'($urandom), 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    // stall released while beats keep coming, then resync and recapture
    beats(32, 1'b0);
    beats(3, 1'b1);
    cyc(1'b0, '0, 1'b1);
    beats(16, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    // random traffic
    for (int t = 0; t < 600; t++)
      cyc($urandom_range(0, 9) != 0, 9'($urandom), $urandom_range(0, 2) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
